// File: rtl/gps_gen_pkg.sv
// Shared constants and encodings for the navigation message path of the GPS generator.
package gps_gen_pkg;

  localparam logic [7:0] NAV_PREAMBLE     = 8'h8B;
  localparam logic [7:0] PRESET_BYTE_ZERO = 8'h00;
  localparam logic [7:0] PRESET_BYTE_ALT  = 8'h55;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_PARITY   = 2'd3
  } nav_state_e;

  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_ALT    = 2'd1,
    SEL_INDEX  = 2'd2,
    SEL_LOADED = 2'd3
  } preset_sel_e;

  function automatic logic [7:0] preset_byte(input preset_sel_e sel, input int idx,
                                             input logic [7:0] loaded);
    logic [7:0] b;
    case (sel)
      SEL_ZERO:  b = PRESET_BYTE_ZERO;
      SEL_ALT:   b = PRESET_BYTE_ALT;
      SEL_INDEX: b = 8'(idx);
      default:   b = loaded;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nav_msg_gen_if.sv
// Payload load port: byte-wide valid/ready handshake into the double buffer.
interface nav_msg_gen_if;
  logic       ld_valid_in;
  logic [7:0] ld_data_in;
  logic       ld_ready_out;

  modport master (output ld_valid_in, output ld_data_in, input  ld_ready_out);
  modport slave  (input  ld_valid_in, input  ld_data_in, output ld_ready_out);
endinterface

// File: rtl/nav_msg_ld_buf.sv
// Double-buffered payload store: shadow filled over the load port, copied to active on commit.
module nav_msg_ld_buf
  import gps_gen_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  nav_msg_gen_if.slave                  ld,
  input  logic                          i_commit,
  output logic [PAYLOAD_BYTES-1:0][7:0] o_active
);

  localparam int PW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  logic [PAYLOAD_BYTES-1:0][7:0] r_shadow;
  logic [PAYLOAD_BYTES-1:0][7:0] r_active;
  logic [PW-1:0]                 r_wptr;
  logic                          r_pending;
  logic                          w_accept;

  assign ld.ld_ready_out = ~r_pending;
  assign w_accept        = ld.ld_valid_in & ~r_pending;
  assign o_active        = r_active;

  // Commit needs pending set before this edge, so a final byte landing on the
  // commit edge waits for the next commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_wptr    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_commit && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      if (w_accept) begin
        r_shadow[r_wptr] <= ld.ld_data_in;
        if (r_wptr == PW'(PAYLOAD_BYTES-1)) begin
          r_wptr    <= '0;
          r_pending <= 1'b1;
        end else begin
          r_wptr <= r_wptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nav_msg_gen.sv
// Navigation bit source: preamble + payload + even parity framing, epoch-aligned,
// with a raw passthrough mode and per-bit / per-frame strobes.
module nav_msg_gen
  import gps_gen_pkg::*;
#(
  parameter int PAYLOAD_BYTES  = 4,
  parameter int EPOCHS_PER_BIT = 20
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         ena_in,
  input  logic         epoch_in,
  input  logic         use_msg_preset_in,
  input  logic [1:0]   preset_sel_in,
  input  logic         msg_in,
  nav_msg_gen_if.slave ld,
  output logic         msg_out,
  output logic         bit_start_out,
  output logic         frame_start_out
);

  localparam int PBITS = 8 * PAYLOAD_BYTES;
  localparam int BW    = $clog2(PBITS);
  localparam int EW    = $clog2(EPOCHS_PER_BIT);

  nav_state_e  r_state, w_state_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic [EW-1:0] r_ecnt;
  logic        r_use_preset;
  preset_sel_e r_sel;
  logic        r_msg, r_bit_start, r_frame_start;

  logic        w_counted, w_boundary, w_frame_start;
  logic        w_use_preset, w_gen_bit, w_bit_nxt;
  logic [PAYLOAD_BYTES-1:0][7:0] w_active;
  logic [PBITS-1:0]              w_pay_flat;

  nav_msg_ld_buf #(.PAYLOAD_BYTES(PAYLOAD_BYTES)) u_ld_buf (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .ld       (ld),
    .i_commit (w_frame_start),
    .o_active (w_active)
  );

  // Payload flattened in transmission order: byte 0 MSB sits at the top bit.
  for (genvar g = 0; g < PAYLOAD_BYTES; g++) begin : g_pay
    assign w_pay_flat[PBITS-1-8*g -: 8] = preset_byte(r_sel, g, w_active[g]);
  end

  assign w_counted  = ena_in & epoch_in;
  assign w_boundary = w_counted &
                      ((r_state == ST_IDLE) || (r_ecnt == EW'(EPOCHS_PER_BIT-1)));

  always_comb begin
    w_state_nxt   = r_state;
    w_bcnt_nxt    = r_bcnt;
    w_frame_start = 1'b0;
    if (w_boundary) begin
      case (r_state)
        ST_PREAMBLE: begin
          if (r_bcnt == BW'(7)) begin
            w_state_nxt = ST_PAYLOAD;
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (r_bcnt == BW'(PBITS-1)) begin
            w_state_nxt = ST_PARITY;
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt   = ST_PREAMBLE;
          w_bcnt_nxt    = '0;
          w_frame_start = 1'b1;
        end
      endcase
    end
  end

  // Bit value for the state/index being entered; mode comes straight from the
  // input on the frame-start boundary since the register is still loading.
  always_comb begin
    w_use_preset = w_frame_start ? use_msg_preset_in : r_use_preset;
    case (w_state_nxt)
      ST_PREAMBLE: w_gen_bit = NAV_PREAMBLE[3'd7 - w_bcnt_nxt[2:0]];
      ST_PAYLOAD:  w_gen_bit = w_pay_flat[BW'(PBITS-1) - w_bcnt_nxt];
      ST_PARITY:   w_gen_bit = ^w_pay_flat;
      default:     w_gen_bit = 1'b0;
    endcase
    w_bit_nxt = w_use_preset ? w_gen_bit : msg_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_bcnt        <= '0;
      r_ecnt        <= '0;
      r_use_preset  <= 1'b0;
      r_sel         <= SEL_ZERO;
      r_msg         <= 1'b0;
      r_bit_start   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_bit_start   <= w_boundary;
      r_frame_start <= w_frame_start;
      if (w_boundary) begin
        r_bcnt <= w_bcnt_nxt;
        r_ecnt <= '0;
        r_msg  <= w_bit_nxt;
        if (w_frame_start) begin
          r_use_preset <= use_msg_preset_in;
          r_sel        <= preset_sel_e'(preset_sel_in);
        end
      end else if (w_counted) begin
        r_ecnt <= r_ecnt + 1'b1;
      end
    end
  end

  assign msg_out         = r_msg;
  assign bit_start_out   = r_bit_start;
  assign frame_start_out = r_frame_start;

endmodule

// File: tb/tb_nav_msg_gen.sv
// Randomized + directed bench for nav_msg_gen with a frame-level reference model and scoreboard.
module tb_nav_msg_gen;

  localparam int PB         = 4;
  localparam int EPB        = 2;
  localparam int BIT_PER5   = EPB * 5;
  localparam int FRAME_PER5 = (9 + 8 * PB) * EPB * 5;

  typedef struct packed { logic bitv; logic fs; } exp_t;

  logic clk = 1'b0;
  logic rst, ena, epoch, use_preset, msg_in;
  logic [1:0] sel;
  logic msg_out, bit_start, frame_start;

  nav_msg_gen_if ldif ();

  nav_msg_gen #(.PAYLOAD_BYTES(PB), .EPOCHS_PER_BIT(EPB)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .ena_in            (ena),
    .epoch_in          (epoch),
    .use_msg_preset_in (use_preset),
    .preset_sel_in     (sel),
    .msg_in            (msg_in),
    .ld                (ldif),
    .msg_out           (msg_out),
    .bit_start_out     (bit_start),
    .frame_start_out   (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  bit        m_started = 0;
  int        m_ecnt = 0;
  bit        m_pend = 0;
  int        m_wptr = 0;
  bit        m_msg = 0;
  bit        m_use = 0;
  int        m_sel = 0;
  logic [7:0] m_shadow [PB];
  logic [7:0] m_active [PB];
  bit        m_frame [$];
  exp_t      exp_q [$];

  initial for (int i = 0; i < PB; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end

  always @(posedge clk) begin : model
    logic acc, fs, b, par;
    logic [7:0] by, pre;
    if (rst) begin
      m_started = 0; m_ecnt = 0; m_pend = 0; m_wptr = 0; m_msg = 0;
      for (int i = 0; i < PB; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end
      m_frame.delete();
      exp_q.delete();
    end else begin
      acc = ldif.ld_valid_in && !m_pend;
      if (ena && epoch) begin
        if (!m_started || m_ecnt == EPB - 1) begin
          m_ecnt = 0;
          fs = 0;
          if (m_frame.size() == 0) begin
            fs = 1;
            m_started = 1;
            if (m_pend) begin m_active = m_shadow; m_pend = 0; end
            m_use = use_preset;
            m_sel = int'(sel);
            pre = 8'h8B;
            for (int i = 7; i >= 0; i--) m_frame.push_back(pre[i]);
            par = 0;
            for (int j = 0; j < PB; j++) begin
              case (m_sel)
                0:       by = 8'h00;
                1:       by = 8'h55;
                2:       by = 8'(j);
                default: by = m_active[j];
              endcase
              for (int i = 7; i >= 0; i--) m_frame.push_back(by[i]);
              par = par ^ ($countones(by) % 2 == 1);
            end
            m_frame.push_back(par);
          end
          b = m_frame.pop_front();
          if (!m_use) b = msg_in;
          m_msg = b;
          exp_q.push_back('{bitv: b, fs: fs});
        end else begin
          m_ecnt++;
        end
      end
      if (acc) begin
        m_shadow[m_wptr] = ldif.ld_data_in;
        m_wptr++;
        if (m_wptr == PB) begin m_wptr = 0; m_pend = 1; end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit chk_en = 0;
  bit per_chk = 0;
  int cyc = 0;
  int last_bs = -1;
  int last_fs = -1;

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (!per_chk) begin last_bs = -1; last_fs = -1; end
    if (chk_en) begin
      chk("ld_ready", int'(ldif.ld_ready_out), int'(!m_pend));
      chk("msg_level", int'(msg_out), int'(m_msg));
      if (bit_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("bit_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("bit_value", int'(msg_out), int'(e.bitv));
          chk("frame_start", int'(frame_start), int'(e.fs));
        end
        if (per_chk) begin
          if (last_bs >= 0) chk("bit_period", cyc - last_bs, BIT_PER5);
          last_bs = cyc;
          if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME_PER5);
            last_fs = cyc;
          end
        end
      end else begin
        chk("bit_start_low", int'(bit_start), 0);
        chk("fs_without_bit", int'(frame_start), 0);
        if (exp_q.size() != 0) begin
          fail_now("bit_missing");
          exp_q.delete();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] ld_q [$];
  bit   rdy_prev = 1;
  bit   tog = 0;
  bit   inject_armed = 0;
  bit   injected = 0;
  logic [7:0] inject_byte = 8'h00;

  task automatic drive_cycle(input bit ep);
    @(negedge clk);
    if (ldif.ld_valid_in && rdy_prev && ld_q.size() > 0) void'(ld_q.pop_front());
    if (inject_armed && ep && ena && m_started && m_frame.size() == 0 &&
        m_ecnt == EPB - 1 && ld_q.size() == 0 && !m_pend && m_wptr == PB - 1) begin
      ld_q.push_back(inject_byte);
      inject_armed = 0;
      injected = 1;
    end
    epoch = ep;
    if (tog) msg_in = ~msg_in;
    ldif.ld_valid_in = (ld_q.size() > 0);
    ldif.ld_data_in  = (ld_q.size() > 0) ? ld_q[0] : 8'h00;
    rdy_prev = ldif.ld_ready_out;
  endtask

  task automatic run(input int n, input int eper);
    for (int i = 0; i < n; i++) drive_cycle(i % eper == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; epoch = 0; ldif.ld_valid_in = 1'b0; ld_q.delete();
    @(negedge clk);
    chk("rst_msg", int'(msg_out), 0);
    chk("rst_bit_start", int'(bit_start), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_ld_ready", int'(ldif.ld_ready_out), 1);
    rst = 0;
    rdy_prev = 1;
  endtask

  task automatic wait_payload(input string name);
    int n = 0;
    while (!(m_started && m_frame.size() == 20) && n < 400) begin drive_cycle(1); n++; end
    if (n >= 400) fail_now(name);
  endtask

  initial begin
    rst = 1; ena = 1; epoch = 0; use_preset = 1; sel = 2'd1; msg_in = 0;
    ldif.ld_valid_in = 1'b0; ldif.ld_data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_msg", int'(msg_out), 0);
    chk("rst_bit_start", int'(bit_start), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_ld_ready", int'(ldif.ld_ready_out), 1);
    chk_en = 1;
    rst = 0;

    // 0x55 preset, one epoch every 5 cycles
    per_chk = 1;
    run(900, 5);
    per_chk = 0;

    // index preset, then loaded payload 01 00 00 00
    sel = 2'd2;
    run(200, 1);
    sel = 2'd3;
    ld_q.push_back(8'h01); ld_q.push_back(8'h00); ld_q.push_back(8'h00); ld_q.push_back(8'h00);
    run(300, 1);

    // final byte accepted on the frame-start edge
    ld_q.push_back(8'hAA); ld_q.push_back(8'hBB); ld_q.push_back(8'hCC);
    run(20, 1);
    inject_byte = 8'hDD; inject_armed = 1; injected = 0;
    begin
      int n = 0;
      while (!injected && n < 300) begin drive_cycle(1); n++; end
      if (!injected) begin fail_now("timeout_inject"); inject_armed = 0; end
    end
    run(250, 1);

    // passthrough with msg_in toggling every cycle
    do_reset();
    use_preset = 0; tog = 1; per_chk = 1;
    run(900, 5);
    per_chk = 0; tog = 0; use_preset = 1; sel = 2'd1;

    // enable dropped mid-payload while epochs keep arriving
    run(100, 1);
    wait_payload("timeout_ena_payload");
    ena = 0;
    run(30, 1);
    ena = 1;
    run(200, 1);

    // reset mid-payload after a partial load
    sel = 2'd3;
    ld_q.push_back(8'h5A); ld_q.push_back(8'hA5);
    wait_payload("timeout_rst_payload");
    chk("partial_wptr", m_wptr, 2);
    do_reset();
    ld_q.push_back(8'h11); ld_q.push_back(8'h22); ld_q.push_back(8'h33); ld_q.push_back(8'h44);
    run(8, 100);
    run(200, 1);

    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 2999) == 0);
      ena        = ($urandom_range(0, 7) != 0);
      epoch      = ($urandom_range(0, 2) == 0);
      use_preset = ($urandom_range(0, 3) != 0);
      sel        = 2'($urandom_range(0, 3));
      msg_in     = 1'($urandom_range(0, 1));
      ldif.ld_valid_in = 1'($urandom_range(0, 1));
      ldif.ld_data_in  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst = 0; ena = 1; epoch = 0; ldif.ld_valid_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
